ppl_mem_arb: RTL and testbench

- Arbiter/sequencer sharing one unified single-port memory between the pipeline fetch stage (instruction port, read-only) and the MEM stage (data port, read/write).
- Sits between the pipeline stages and the memory.
- Supplies stall signals that freeze the requesting stages while their access is in flight.
- Data port has priority, with a fairness counter so fetch is never starved, and a watchdog that aborts a memory that never acknowledges.

---
 rtl/ppl_mem_arb.sv | 231 +++++++++++++++++++++++
 tb/tb_ppl_mem_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppl_mem_arb.sv
// ppl_mem_arb
// -----------
// Shares one single-port memory between the pipeline fetch stage (read-only
// instruction port) and the MEM stage (read/write data port). Only one memory
// transaction is outstanding at a time. The data port normally wins, but a
// fairness counter hands the memory to fetch after FAIR_MAX consecutive data
// grants taken while fetch was waiting. A watchdog aborts a memory access
// that is not acknowledged within TIMEOUT cycles and raises a sticky error.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   if_req / if_addr      fetch read request (level, held until if_done)
//   if_rdata / if_done    fetched word and its one-cycle completion pulse
//   if_stall              if_req & ~if_done
//   dm_req / dm_we        data request (level) and write enable
//   dm_addr / dm_wdata    data address and write data
//   dm_rdata / dm_done    read data and its one-cycle completion pulse
//   dm_stall              dm_req & ~dm_done
//   mem_req/we/addr/wdata registered memory request, held until ack/abort
//   mem_rdata / mem_ack   memory read data and one-cycle acknowledge
//   mem_err               sticky watchdog-timeout flag
//
// Parameters
//   AW, DW     address / data width
//   FAIR_MAX   data grants allowed while fetch waits (0 = strict priority)
//   TIMEOUT    wait cycles before an access is aborted (1..65535)

module ppl_mem_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_err
);

  // Fairness counter is wide enough to hold FAIR_MAX; with FAIR_MAX = 0 it
  // degenerates to a single bit that never leaves zero.
  localparam int FW = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;
  localparam logic [FW-1:0] FAIR_LIM = FW'(FAIR_MAX);
  // The watchdog holds the number of completed wait cycles; the abort fires in
  // the wait cycle that would bring it to TIMEOUT.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_I,
    WAIT_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            mem_err_q, mem_err_d;
  logic [FW-1:0]   fair_q, fair_d;
  logic [15:0]     wd_q, wd_d;

  logic            fetch_turn;
  logic            grant_data;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_err_q   <= 1'b0;
      fair_q      <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_err_q   <= mem_err_d;
      fair_q      <= fair_d;
      wd_q        <= wd_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_err_d   = mem_err_q;
    fair_d      = fair_q;
    wd_d        = wd_q;

    // Fetch takes its turn only when both are asking and data has used up
    // its allowance of back-to-back grants.
    fetch_turn  = (FAIR_MAX != 0) && (fair_q == FAIR_LIM);
    grant_data  = dm_req && !(if_req && fetch_turn);

    case (state_q)
      IDLE: begin
        if (dm_req || if_req) begin
          mem_req_d = 1'b1;
          wd_d      = '0;
          if (grant_data) begin
            state_d     = WAIT_D;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            // Only grants that made fetch wait count against the allowance.
            if (if_req && (fair_q != FAIR_LIM)) begin
              fair_d = fair_q + FW'(1);
            end
          end else begin
            state_d     = WAIT_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            fair_d      = '0;
          end
        end
      end

      WAIT_I, WAIT_D: begin
        wd_d = wd_q + 16'd1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (state_q == WAIT_I) begin
            if_rdata_d = mem_rdata;
            state_d    = RESP_I;
          end else begin
            // A write returns no data; keep the last read value visible.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            state_d = RESP_D;
          end
        end else if (wd_q == WD_LAST) begin
          // Memory never answered: release the bus, flag the error and
          // complete the requester with zero data so the pipeline moves on.
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          if (state_q == WAIT_I) begin
            if_rdata_d = '0;
            state_d    = RESP_I;
          end else begin
            dm_rdata_d = '0;
            state_d    = RESP_D;
          end
        end
      end

      // Completion cycle; requests are not looked at until back in IDLE.
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // Done pulses come straight from the state register, so nothing on the
  // memory side reaches an output combinationally.
  assign if_done   = (state_q == RESP_I);
  assign dm_done   = (state_q == RESP_D);

  // Per-port stall: port 0 is fetch, port 1 is data.
  logic [1:0] port_req;
  logic [1:0] port_done;
  logic [1:0] port_stall;

  assign port_req  = {dm_req, if_req};
  assign port_done = {dm_done, if_done};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stall
    assign port_stall[gi] = port_req[gi] & ~port_done[gi];
  end

  assign if_stall = port_stall[0];
  assign dm_stall = port_stall[1];

endmodule

// File: tb/tb_ppl_mem_arb.sv
// Bench for ppl_mem_arb. Instance dut_a uses FAIR_MAX=2, TIMEOUT=8 and is
// checked every cycle against a transaction-level reference model; instance
// dut_b uses FAIR_MAX=0 for the strict-priority scenario.

module tb_ppl_mem_arb;

  localparam int FAIR_A = 2;
  localparam int TO_A   = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_req, mem_we, mem_err;

  logic        b_if_req, b_dm_req, b_mem_ack;
  logic [31:0] b_mem_rdata, b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_done, b_if_stall, b_dm_done, b_dm_stall;
  logic        b_mem_req, b_mem_we, b_mem_err;

  always #5 clock = ~clock;

  ppl_mem_arb #(.AW(32), .DW(32), .FAIR_MAX(FAIR_A), .TIMEOUT(TO_A)) dut_a (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err)
  );

  ppl_mem_arb #(.AW(32), .DW(32), .FAIR_MAX(0), .TIMEOUT(TO_A)) dut_b (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(if_addr), .if_rdata(b_if_rdata),
    .if_done(b_if_done), .if_stall(b_if_stall),
    .dm_req(b_dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_done(b_dm_done), .dm_stall(b_dm_stall),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .mem_err(b_mem_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model of dut_a
  bit          m_busy, m_resp, m_own_d, m_we, m_err;
  int          m_wait, m_fair;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  // memory model and bookkeeping
  logic [31:0] mem_arr [logic [31:0]];
  bit          mem_en, force_ack, rand_lat, prev_mem_req;
  int          cur_lat, lat_cnt, req_hi;
  bit          gl_we [$];
  logic [31:0] gl_addr [$];
  int          gl_cyc [$];
  bit          saw_if, saw_dm;
  int          if_done_cyc, dm_done_cyc, n_done, b_if_n, b_dm_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic tick();
    logic        s_reset, s_if, s_dm, s_we, s_ack;
    logic [31:0] s_if_addr, s_dm_addr, s_wdata, s_rdata;
    bit          gd;
    s_reset = reset;   s_if = if_req;       s_dm = dm_req;
    s_we = dm_we;      s_ack = mem_ack;     s_if_addr = if_addr;
    s_dm_addr = dm_addr; s_wdata = dm_wdata; s_rdata = mem_rdata;
    @(posedge clock);
    #1;
    cyc++;

    // reference model: one transaction at a time, done the cycle after
    // completion, arbitration in the first free cycle after that
    if (s_reset) begin
      m_busy = 0; m_resp = 0; m_own_d = 0; m_wait = 0; m_fair = 0;
      m_addr = '0; m_we = 0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0; m_err = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      m_wait++;
      if (s_ack) begin
        m_busy = 0; m_resp = 1;
        if (!m_own_d) m_if_rdata = s_rdata;
        else if (!m_we) m_dm_rdata = s_rdata;
      end else if (m_wait == TO_A) begin
        m_busy = 0; m_resp = 1; m_err = 1;
        if (m_own_d) m_dm_rdata = '0;
        else m_if_rdata = '0;
      end
    end else if (s_if || s_dm) begin
      gd = s_dm && !(s_if && FAIR_A != 0 && m_fair == FAIR_A);
      m_busy = 1; m_wait = 0; m_own_d = gd;
      if (gd) begin
        if (s_if && m_fair < FAIR_A) m_fair++;
        m_addr = s_dm_addr; m_we = s_we; m_wdata = s_wdata;
      end else begin
        m_fair = 0; m_addr = s_if_addr; m_we = 0;
      end
    end

    chk("mem_req", mem_req, m_busy);
    chk("if_done", if_done, m_resp && !m_own_d);
    chk("dm_done", dm_done, m_resp && m_own_d);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_we", mem_we, m_we);
    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("mem_err", mem_err, m_err);
    chk("if_stall", if_stall, if_req && !(m_resp && !m_own_d));
    chk("dm_stall", dm_stall, dm_req && !(m_resp && m_own_d));

    if (mem_req) req_hi++;
    if (mem_req && !prev_mem_req) begin
      gl_we.push_back(mem_we);
      gl_addr.push_back(mem_addr);
      gl_cyc.push_back(cyc);
      if (rand_lat) cur_lat = $urandom_range(1, 4);
    end
    prev_mem_req = mem_req;
    if (if_done) begin
      saw_if = 1; if_done_cyc = cyc; n_done++;
      $display("[%0d] fetch done addr=%h rdata=%h", cyc, if_addr, if_rdata);
    end
    if (dm_done) begin
      saw_dm = 1; dm_done_cyc = cyc; n_done++;
      $display("[%0d] data done we=%0d addr=%h rdata=%h", cyc, dm_we, dm_addr, dm_rdata);
    end
    if (b_if_done) b_if_n++;
    if (b_dm_done) b_dm_n++;

    // memory responder for dut_a
    if (force_ack) begin
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; force_ack = 0;
    end else if (mem_req && mem_en) begin
      lat_cnt++;
      if (lat_cnt == cur_lat) begin
        mem_ack = 1;
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_read(mem_addr);
        end
      end else begin
        mem_ack = 0; mem_rdata = $urandom;
      end
    end else begin
      mem_ack = 0; mem_rdata = $urandom;
      if (!mem_req) lat_cnt = 0;
    end
    // dut_b memory: one-cycle latency
    b_mem_ack = b_mem_req && !b_mem_ack;
    b_mem_rdata = $urandom;
  endtask

  task automatic wait_done(input bit data, input int bound);
    saw_if = 0; saw_dm = 0;
    for (int i = 0; i < bound && !(data ? saw_dm : saw_if); i++) tick();
    chk(data ? "wait_dm_done" : "wait_if_done", data ? saw_dm : saw_if, 1'b1);
  endtask

  task automatic clear_log();
    gl_we.delete(); gl_addr.delete(); gl_cyc.delete();
  endtask

  initial begin
    int d1;
    bit exp_pat [6];
    reset = 1; if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0;
    dm_wdata = '0; mem_ack = 0; mem_rdata = '0; b_if_req = 0; b_dm_req = 0;
    b_mem_ack = 0; b_mem_rdata = '0; mem_en = 1; cur_lat = 1; force_ack = 0;
    rand_lat = 0; prev_mem_req = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", {if_done, dm_done, mem_err}, 3'b000);

    // fetch alone, ack in the third request cycle
    mem_arr[32'h100] = 32'h8C01_0004;
    cur_lat = 3; req_hi = 0; clear_log();
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("f_stall", if_stall, 1'b1);
    wait_done(0, 20);
    chk("f_rdata", if_rdata, 32'h8C01_0004);
    chk("f_req_cycles", req_hi, 3);
    chk("f_we", gl_we[0], 1'b0);
    if_req = 0;
    tick();

    // simultaneous requests: data write first, then fetch
    clear_log(); cur_lat = 2;
    mem_arr[32'h104] = 32'h1234_5678;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hCAFE_F00D;
    if_req = 1; if_addr = 32'h104;
    wait_done(1, 20);
    dm_req = 0;
    wait_done(0, 20);
    if_req = 0;
    tick();
    chk("sim_grants", gl_we.size(), 2);
    chk("sim_first_we", gl_we[0], 1'b1);
    chk("sim_first_addr", gl_addr[0], 32'h2000);
    chk("sim_written", mem_read(32'h2000), 32'hCAFE_F00D);
    chk("sim_second_addr", gl_addr[1], 32'h104);
    chk("sim_fetch_gap", gl_cyc[1], dm_done_cyc + 2);
    chk("sim_dm_rdata", dm_rdata, 32'h0);
    chk("sim_if_rdata", if_rdata, 32'h1234_5678);

    // fairness with FAIR_MAX=2: D D I D D I
    clear_log(); cur_lat = 1;
    dm_we = 1; dm_addr = 32'h2100; dm_wdata = 32'h1111_0000; if_addr = 32'h500;
    if_req = 1; dm_req = 1;
    for (int i = 0; i < 200 && gl_we.size() < 6; i++) tick();
    dm_req = 0;
    wait_done(0, 20);
    if_req = 0;
    tick();
    exp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) chk($sformatf("fair_order_%0d", i), gl_we[i], exp_pat[i]);

    // strict priority on dut_b
    b_if_n = 0; b_dm_n = 0;
    b_if_req = 1; b_dm_req = 1;
    repeat (40) tick();
    chk("strict_no_fetch", b_if_n, 0);
    chk("strict_data_flow", b_dm_n >= 8, 1'b1);
    b_dm_req = 0;
    for (int i = 0; i < 20 && b_if_n == 0; i++) tick();
    b_if_req = 0;
    chk("strict_fetch_after", b_if_n >= 1, 1'b1);
    repeat (4) tick();

    // back-to-back fetch with a new address
    clear_log(); cur_lat = 1;
    if_req = 1; if_addr = 32'h400;
    wait_done(0, 20);
    d1 = if_done_cyc; if_addr = 32'h404;
    wait_done(0, 20);
    if_req = 0;
    tick();
    chk("b2b_grants", gl_addr.size(), 2);
    chk("b2b_addr0", gl_addr[0], 32'h400);
    chk("b2b_addr1", gl_addr[1], 32'h404);
    chk("b2b_gap", gl_cyc[1], d1 + 2);

    // randomized traffic
    rand_lat = 1; n_done = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (if_req && if_done) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      end
      if (dm_req && dm_done) dm_req = 0;
      else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        dm_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      end
    end
    for (int i = 0; i < 60 && (if_req || dm_req); i++) begin
      tick();
      if (if_done) if_req = 0;
      if (dm_done) dm_req = 0;
    end
    rand_lat = 0;
    chk("rand_drained", {if_req, dm_req}, 2'b00);
    chk("rand_txns", n_done >= 20, 1'b1);
    tick();

    // data read of the earlier write
    cur_lat = 2; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    wait_done(1, 20);
    dm_req = 0;
    chk("rd_back", dm_rdata, 32'hCAFE_F00D);
    tick();

    // timeout: no ack
    mem_en = 0; req_hi = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    wait_done(1, 30);
    dm_req = 0;
    chk("to_rdata", dm_rdata, 32'h0);
    chk("to_req_cycles", req_hi, 8);
    chk("to_err", mem_err, 1'b1);
    mem_en = 1; force_ack = 1;
    repeat (3) tick();
    chk("to_err_sticky", mem_err, 1'b1);
    chk("to_late_ack", {mem_req, if_done, dm_done}, 3'b000);

    // reset during a data wait
    cur_lat = 6; req_hi = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    for (int i = 0; i < 20 && req_hi < 2; i++) tick();
    reset = 1; dm_req = 0;
    tick();
    reset = 0;
    chk("rr_mem_req", mem_req, 1'b0);
    chk("rr_mem_addr", mem_addr, 32'h0);
    chk("rr_dm_rdata", dm_rdata, 32'h0);
    chk("rr_err", mem_err, 1'b0);
    force_ack = 1;
    repeat (2) tick();
    chk("rr_no_done", {if_done, dm_done, mem_req}, 3'b000);
    cur_lat = 2; if_req = 1; if_addr = 32'h100;
    wait_done(0, 20);
    if_req = 0;
    chk("rr_fetch", if_rdata, 32'h8C01_0004);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
